// File: rtl/game_pkg.sv
// Shared types and constants for the game front end: player count, choice width, channel FSM states.
// Pure definitions, no logic or timing of its own.
package game_pkg;
    localparam int NUM_PLAYERS  = 6;
    localparam int CHOICE_W     = 3;
    localparam int CHOICE_BUS_W = NUM_PLAYERS * CHOICE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        PULSE = 2'd2
    } chan_state_t;

    // Player idx occupies bits [CHOICE_W*idx +: CHOICE_W] of a packed choice bus.
    function automatic logic [CHOICE_W-1:0] choice_slice(input logic [CHOICE_BUS_W-1:0] bus,
                                                         input int idx);
        return bus[idx*CHOICE_W +: CHOICE_W];
    endfunction
endpackage

// File: rtl/player_input_channel.sv
// One player: synchronize button+choice, debounce the button, emit a choice-then-pulse per accepted press.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES to accept, choice one cycle later, pulse the cycle after that.
// No backpressure: presses arriving while busy or while accept_en is low are dropped, never queued.
module player_input_channel
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned PULSE_CYCLES    = 4,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn_raw,
    input  logic [CHOICE_W-1:0] choice_raw,
    input  logic                accept_en,
    output logic                player_clk,
    output logic [CHOICE_W-1:0] player_choice,
    output logic                press_seen,
    output logic                busy,
    output logic                pulse_end
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW    = $clog2(PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0]    PULSE_TOP = PW'(PULSE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][CHOICE_W:0] sync_q;
    logic                sync_btn;
    logic [CHOICE_W-1:0] sync_choice;
    logic [CNT_W-1:0]    db_cnt;
    logic                stable;
    logic                stable_q;
    logic                press;
    chan_state_t         state;
    logic [PW-1:0]       pulse_cnt;

    assign sync_btn    = sync_q[SYNC_STAGES-1][0];
    assign sync_choice = sync_q[SYNC_STAGES-1][CHOICE_W:1];
    assign press       = stable & ~stable_q;
    assign busy        = (state != IDLE);
    assign pulse_end   = (state == PULSE) && (pulse_cnt == '0);

    // Choice bits share the button's synchronizer so both arrive with equal delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= {choice_raw, btn_raw};
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt   <= '0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            stable_q <= stable;
            if (sync_btn == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                stable <= sync_btn;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pulse_cnt     <= '0;
            player_clk    <= 1'b0;
            player_choice <= '0;
            press_seen    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (press && accept_en) begin
                        state         <= LOAD;
                        player_choice <= sync_choice;
                        press_seen    <= 1'b1;
                    end
                end
                LOAD: begin
                    state      <= PULSE;
                    player_clk <= 1'b1;
                    pulse_cnt  <= PULSE_TOP;
                end
                PULSE: begin
                    if (pulse_cnt == '0) begin
                        player_clk <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        pulse_cnt <= pulse_cnt - 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    player_clk <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/player_input_conditioner.sv
// Conditions six players' raw buttons/choices into clean press pulses plus held choices for the game FSM.
// Latency: per channel, choice valid one cycle before its pulse; reset assert is async, release is synchronized.
// No backpressure: game_over (and PLAYER_INPUT_LOCKOUT_EN's global lockout, when defined) drops new presses.
module player_input_conditioner
    import game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned PULSE_CYCLES    = 4,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_PLAYERS-1:0]  btn_raw,
    input  logic [CHOICE_BUS_W-1:0] choice_raw,
    input  logic                    game_over,
    output logic [NUM_PLAYERS-1:0]  player_clk,
    output logic [CHOICE_BUS_W-1:0] player_choice,
    output logic [NUM_PLAYERS-1:0]  press_seen
);
    logic [1:0]             rst_sync;
    logic                   rst_n;
    logic                   accept_en;
    logic [NUM_PLAYERS-1:0] busy;
    logic [NUM_PLAYERS-1:0] pulse_end;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n = rst_sync[1];

`ifdef PLAYER_INPUT_LOCKOUT_EN
    localparam int LW = $clog2(PULSE_CYCLES + 1);
    logic [LW-1:0] lock_cnt;

    // Any finishing pulse arms a global quiet window; any busy channel blocks new starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
        end else if (|pulse_end) begin
            lock_cnt <= LW'(PULSE_CYCLES);
        end else if (lock_cnt != '0) begin
            lock_cnt <= lock_cnt - 1'b1;
        end
    end
    assign accept_en = ~game_over && (lock_cnt == '0) && ~(|busy);
`else
    logic unused_status;
    assign unused_status = ^{busy, pulse_end};
    assign accept_en     = ~game_over;
`endif

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_chan
        player_input_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .PULSE_CYCLES    (PULSE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .btn_raw       (btn_raw[i]),
            .choice_raw    (choice_slice(choice_raw, i)),
            .accept_en     (accept_en),
            .player_clk    (player_clk[i]),
            .player_choice (player_choice[i*CHOICE_W +: CHOICE_W]),
            .press_seen    (press_seen[i]),
            .busy          (busy[i]),
            .pulse_end     (pulse_end[i])
        );
    end
endmodule

// File: tb/tb_player_input_conditioner.sv
// Scoreboard bench: a cycle-indexed history model predicts accepted presses; a monitor checks pulses/choices.
module tb_player_input_conditioner;
    localparam int DB = 4;
    localparam int PC = 2;
    localparam int NP = 6;
    localparam int HN = 1024;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  btn_raw = '0;
    logic [17:0] choice_raw = '0;
    logic        game_over = 1'b0;
    logic [5:0]  player_clk;
    logic [17:0] player_choice;
    logic [5:0]  press_seen;

    player_input_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .PULSE_CYCLES    (PC),
        .SYNC_STAGES     (2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .btn_raw       (btn_raw),
        .choice_raw    (choice_raw),
        .game_over     (game_over),
        .player_clk    (player_clk),
        .player_choice (player_choice),
        .press_seen    (press_seen)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int         start;
        logic [2:0] choice;
    } exp_t;

    // Reference model: a button level is accepted once it has been seen on the synchronized
    // input (raw sample two edges old) for DB consecutive edges; a rising acceptance becomes a press.
    int          cyc;
    logic [5:0]  btn_h [HN];
    logic [17:0] ch_h  [HN];
    logic        acc [NP];
    int          run [NP];
    bit          pend [NP];
    int          next_free [NP];
    logic [2:0]  held [NP];
    logic [5:0]  exp_seen;
    exp_t        q [NP][$];
    exp_t        model_e;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc      = 0;
            exp_seen = '0;
            for (int i = 0; i < NP; i++) begin
                acc[i] = 1'b0; run[i] = 0; pend[i] = 1'b0; next_free[i] = 0; held[i] = '0;
                q[i].delete();
            end
        end else begin
            cyc++;
            btn_h[cyc % HN] = btn_raw;
            ch_h[cyc % HN]  = choice_raw;
            for (int i = 0; i < NP; i++) begin
                if (pend[i]) begin
                    pend[i] = 1'b0;
                    if (!game_over && cyc >= next_free[i]) begin
                        model_e.start  = cyc + 1;
                        model_e.choice = ch_h[(cyc - 2) % HN][3*i +: 3];
                        held[i]        = model_e.choice;
                        exp_seen[i]    = 1'b1;
                        q[i].push_back(model_e);
                        next_free[i]   = cyc + 2 + PC;
                    end
                end
                if (cyc >= 3) begin
                    if (btn_h[(cyc - 2) % HN][i] != acc[i]) begin
                        run[i]++;
                        if (run[i] == DB) begin
                            acc[i] = ~acc[i];
                            run[i] = 0;
                            if (acc[i]) pend[i] = 1'b1;
                        end
                    end else begin
                        run[i] = 0;
                    end
                end
            end
        end
    end

    logic [5:0]  prev_clk;
    logic [17:0] prev_choice;
    int          width [NP];
    int          pulses [NP];
    int          rise_cyc [NP];
    exp_t        mon_e;

    initial begin
        for (int i = 0; i < NP; i++) begin pulses[i] = 0; rise_cyc[i] = -1; end
    end

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_clk    = '0;
            prev_choice = '0;
            for (int i = 0; i < NP; i++) width[i] = 0;
        end else begin
            check("press_seen", int'(press_seen), int'(exp_seen));
            for (int i = 0; i < NP; i++) begin
                check($sformatf("held_choice_p%0d", i + 1), int'(player_choice[3*i +: 3]), int'(held[i]));
                if (player_clk[i] && !prev_clk[i]) begin
                    pulses[i]++;
                    rise_cyc[i] = cyc;
                    width[i]    = 1;
                    check($sformatf("pulse_expected_p%0d", i + 1), int'(q[i].size() != 0), 1);
                    if (q[i].size() != 0) begin
                        mon_e = q[i].pop_front();
                        check($sformatf("pulse_start_p%0d", i + 1), cyc, mon_e.start);
                        check($sformatf("choice_before_pulse_p%0d", i + 1),
                              int'(prev_choice[3*i +: 3]), int'(mon_e.choice));
                    end
                end else if (player_clk[i] && prev_clk[i]) begin
                    width[i]++;
                end else if (!player_clk[i] && prev_clk[i]) begin
                    check($sformatf("pulse_width_p%0d", i + 1), width[i], PC);
                end
            end
            prev_clk    = player_clk;
            prev_choice = player_choice;
        end
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_player_clk"}, int'(player_clk), 0);
        check({tag, "_player_choice"}, int'(player_choice), 0);
        check({tag, "_press_seen"}, int'(press_seen), 0);
    endtask

    int base [NP];
    task automatic snap();
        for (int i = 0; i < NP; i++) base[i] = pulses[i];
    endtask

    initial begin
        // Reset state
        tick(3);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick(6);

        // Clean press, player 1 choice 101
        snap();
        choice_raw[2:0] = 3'b101;
        btn_raw[0] = 1'b1;
        tick(10);
        btn_raw[0] = 1'b0;
        tick(12);
        check("clean_pulses_p1", pulses[0] - base[0], 1);
        check("clean_choice_p1", int'(player_choice[2:0]), 5);
        check("clean_press_seen", int'(press_seen), 1);

        // Glitch shorter than the debounce window
        snap();
        btn_raw[2] = 1'b1;
        tick(3);
        btn_raw[2] = 1'b0;
        tick(12);
        check("glitch_pulses_p3", pulses[2] - base[2], 0);
        check("glitch_press_seen_p3", int'(press_seen[2]), 0);

        // Bounce then hold
        snap();
        choice_raw[5:3] = 3'b011;
        for (int k = 0; k < 6; k++) begin
            btn_raw[1] = (k % 2 == 0);
            tick(1);
        end
        btn_raw[1] = 1'b1;
        tick(12);
        btn_raw[1] = 1'b0;
        tick(12);
        check("bounce_pulses_p2", pulses[1] - base[1], 1);

        // Simultaneous presses, players 4 and 5
        snap();
        choice_raw[11:9]  = 3'b110;
        choice_raw[14:12] = 3'b010;
        btn_raw[3] = 1'b1;
        btn_raw[4] = 1'b1;
        tick(10);
        btn_raw[3] = 1'b0;
        btn_raw[4] = 1'b0;
        tick(12);
        check("simul_pulses_p4", pulses[3] - base[3], 1);
        check("simul_pulses_p5", pulses[4] - base[4], 1);
        check("simul_same_start", rise_cyc[3], rise_cyc[4]);

        // game_over blocks a new press
        snap();
        game_over = 1'b1;
        choice_raw[17:15] = 3'b111;
        btn_raw[5] = 1'b1;
        tick(10);
        btn_raw[5] = 1'b0;
        tick(10);
        game_over = 1'b0;
        tick(4);
        check("gameover_pulses_p6", pulses[5] - base[5], 0);
        check("gameover_choice_p6", int'(player_choice[17:15]), 0);

        // Reset mid-pulse
        btn_raw[0] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick(1);
            if (player_clk[0]) break;
        end
        check("pulse_before_reset_p1", int'(player_clk[0]), 1);
        reset_n = 1'b0;
        btn_raw[0] = 1'b0;
        #1;
        check_reset_outputs("midpulse_reset");
        tick(3);
        reset_n = 1'b1;
        snap();
        tick(20);
        check("no_pulse_after_reset_p1", pulses[0] - base[0], 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 5) == 0) btn_raw[i] = ~btn_raw[i];
                if ($urandom_range(0, 7) == 0) choice_raw[3*i +: 3] = 3'($urandom);
            end
            if ($urandom_range(0, 39) == 0) game_over = ~game_over;
            tick(1);
        end
        btn_raw   = '0;
        game_over = 1'b0;
        tick(30);
        for (int i = 0; i < NP; i++) begin
            check($sformatf("scoreboard_drained_p%0d", i + 1), q[i].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
